// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-client round-robin UART 8N1 transmitter
// One grant per frame; the IDLE cycle between frames is the arbitration slot.
module uart_tx_sched #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       SYSCLK,
  input  logic       NSYSRESET,
  input  logic       REQ0,
  input  logic [7:0] DATA0,
  output logic       ACK0,
  input  logic       REQ1,
  input  logic [7:0] DATA1,
  output logic       ACK1,
  output logic       TXD,
  output logic       BUSY,
  output logic       LAST_GNT
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_baud, w_baud_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_txd, w_txd_nxt;
  logic        r_ack0, w_ack0_nxt;
  logic        r_ack1, w_ack1_nxt;
  logic        r_last_gnt, w_last_gnt_nxt;
  logic        w_baud_wrap;
  logic        w_gnt;

  assign w_baud_wrap = (r_baud == BAUD_MAX);

  always_ff @(posedge SYSCLK or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      r_state    <= S_IDLE;
      r_baud     <= 16'd0;
      r_bit      <= 3'd0;
      r_shift    <= 8'd0;
      r_txd      <= 1'b1;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_last_gnt <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_txd      <= w_txd_nxt;
      r_ack0     <= w_ack0_nxt;
      r_ack1     <= w_ack1_nxt;
      r_last_gnt <= w_last_gnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_nxt     = r_baud;
    w_bit_nxt      = r_bit;
    w_shift_nxt    = r_shift;
    w_txd_nxt      = r_txd;
    w_ack0_nxt     = 1'b0;
    w_ack1_nxt     = 1'b0;
    w_last_gnt_nxt = r_last_gnt;
    w_gnt          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = 16'd0;
        w_bit_nxt  = 3'd0;
        w_txd_nxt  = 1'b1;
        if (REQ0 || REQ1) begin
          // On a tie the client that was not served last wins.
          w_gnt          = (REQ0 && REQ1) ? ~r_last_gnt : REQ1;
          w_shift_nxt    = w_gnt ? DATA1 : DATA0;
          w_ack0_nxt     = ~w_gnt;
          w_ack1_nxt     = w_gnt;
          w_last_gnt_nxt = w_gnt;
          w_txd_nxt      = 1'b0;
          w_state_nxt    = S_START;
        end
      end
      S_START: begin
        w_baud_nxt = w_baud_wrap ? 16'd0 : r_baud + 16'd1;
        if (w_baud_wrap) begin
          w_txd_nxt   = r_shift[0];
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_baud_nxt = w_baud_wrap ? 16'd0 : r_baud + 16'd1;
        if (w_baud_wrap) begin
          if (r_bit == 3'd7) begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = S_STOP;
          end else begin
            // TXD takes the next bit straight from the pre-shift register.
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_txd_nxt   = r_shift[1];
          end
        end
      end
      S_STOP: begin
        w_baud_nxt = w_baud_wrap ? 16'd0 : r_baud + 16'd1;
        w_txd_nxt  = 1'b1;
        if (w_baud_wrap) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign ACK0     = r_ack0;
  assign ACK1     = r_ack1;
  assign TXD      = r_txd;
  assign BUSY     = (r_state != S_IDLE);
  assign LAST_GNT = r_last_gnt;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - scoreboard bench for uart_tx_sched
// Stimulus pushes expected grants/frames; a monitor pops them on each ACK and checks the frame.
module tb_uart_tx_sched;

  logic       SYSCLK = 1'b0;
  logic       NSYSRESET = 1'b0;
  logic       REQ0 = 1'b0, REQ1 = 1'b0;
  logic [7:0] DATA0 = 8'h00, DATA1 = 8'h00;
  logic       ACK0, ACK1, TXD, BUSY, LAST_GNT;

  logic       req0_87 = 1'b0, req1_87 = 1'b0;
  logic [7:0] data0_87 = 8'h00, data1_87 = 8'h00;
  logic       ack0_87, ack1_87, txd_87, busy_87, gnt_87;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ack_cyc = 0;
  bit mon_busy = 1'b0;

  // frame: bit i is the i-th transmitted bit (bit0 start, bit9 stop)
  typedef struct {
    logic       id;
    logic [9:0] frame;
    int         gap;
    bit         abort;
  } exp_t;
  exp_t exp_q[$];

  uart_tx_sched #(.CLKS_PER_BIT(4)) dut (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET),
    .REQ0(REQ0), .DATA0(DATA0), .ACK0(ACK0),
    .REQ1(REQ1), .DATA1(DATA1), .ACK1(ACK1),
    .TXD(TXD), .BUSY(BUSY), .LAST_GNT(LAST_GNT)
  );

  uart_tx_sched dut87 (
    .SYSCLK(SYSCLK), .NSYSRESET(NSYSRESET),
    .REQ0(req0_87), .DATA0(data0_87), .ACK0(ack0_87),
    .REQ1(req1_87), .DATA1(data1_87), .ACK1(ack1_87),
    .TXD(txd_87), .BUSY(busy_87), .LAST_GNT(gnt_87)
  );

  always #5 SYSCLK = ~SYSCLK;
  always @(posedge SYSCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic push(input logic id, input logic [9:0] frame, input int gap, input bit abort);
    exp_t e;
    e.id = id; e.frame = frame; e.gap = gap; e.abort = abort;
    exp_q.push_back(e);
  endtask

  task automatic wait_q(input int n, input string name);
    int t;
    t = 0;
    while (exp_q.size() > n && t < 200) begin
      @(negedge SYSCLK);
      t++;
    end
    if (exp_q.size() > n) fail_now(name);
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    @(negedge SYSCLK);
    while ((exp_q.size() != 0 || mon_busy) && t < 400) begin
      @(negedge SYSCLK);
      t++;
    end
    if (exp_q.size() != 0 || mon_busy) fail_now(name);
  endtask

  task automatic do_reset(input logic rq0, input logic rq1);
    @(negedge SYSCLK);
    NSYSRESET = 1'b0;
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    #1;
    chk("rst_txd", 64'(TXD), 64'd1);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_acks", 64'({ACK1, ACK0}), 64'd0);
    chk("rst_last_gnt", 64'(LAST_GNT), 64'd1);
    repeat (2) @(negedge SYSCLK);
    REQ0 = rq0;
    REQ1 = rq1;
    NSYSRESET = 1'b1;
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t       e;
    logic [40:0] txd_seq, txd_exp, busy_seq;
    logic        ack_w2;
    bit          aborted;
    forever begin
      @(negedge SYSCLK);
      if (NSYSRESET && (ACK0 || ACK1)) begin
        chk("ack_exclusive", 64'(ACK0 & ACK1), 64'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ack: ACK0=%b ACK1=%b none expected", ACK0, ACK1);
        end else begin
          e = exp_q.pop_front();
          mon_busy = 1'b1;
          chk("ack_id", 64'(ACK1), 64'(e.id));
          chk("last_gnt", 64'(LAST_GNT), 64'(e.id));
          if (e.gap != 0) chk("ack_gap", 64'(cyc - last_ack_cyc), 64'(e.gap));
          last_ack_cyc = cyc;
          txd_seq = '0;
          busy_seq = '0;
          txd_seq[0] = TXD;
          busy_seq[0] = BUSY;
          ack_w2 = 1'b0;
          aborted = 1'b0;
          for (int k = 1; k <= 40; k++) begin
            @(negedge SYSCLK);
            if (!NSYSRESET) begin
              aborted = 1'b1;
              break;
            end
            txd_seq[k] = TXD;
            busy_seq[k] = BUSY;
            if (k == 1) ack_w2 = ACK0 | ACK1;
          end
          chk("abort", 64'(aborted), 64'(e.abort));
          if (!aborted) begin
            for (int k = 0; k < 40; k++) txd_exp[k] = e.frame[k / 4];
            txd_exp[40] = 1'b1;
            chk("frame_txd", 64'(txd_seq), 64'(txd_exp));
            chk("frame_busy", 64'(busy_seq), 64'h0FFFFFFFFFF);
            chk("ack_width", 64'(ack_w2), 64'd0);
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt, high_cnt, busy_cnt, t;

    // Single client 0 frame, 0xA5.
    do_reset(1'b0, 1'b0);
    @(negedge SYSCLK);
    push(1'b0, 10'b1101001010, 0, 1'b0);
    DATA0 = 8'hA5;
    REQ0 = 1'b1;
    wait_q(0, "a5_ack");
    REQ0 = 1'b0;
    wait_idle("a5_frame");

    // Client 1 alone, 0xF0.
    push(1'b1, 10'b1111100000, 0, 1'b0);
    DATA1 = 8'hF0;
    REQ1 = 1'b1;
    wait_q(0, "f0_ack");
    REQ1 = 1'b0;
    wait_idle("f0_frame");

    // REQ pulse between edges in IDLE is never sampled.
    @(posedge SYSCLK);
    #1 REQ0 = 1'b1;
    #3 REQ0 = 1'b0;
    repeat (10) @(negedge SYSCLK);
    chk("glitch_no_frame", 64'(BUSY), 64'd0);

    // Tie at reset release: client 0 first, client 1 one frame later.
    DATA0 = 8'h55;
    DATA1 = 8'h0F;
    push(1'b0, 10'b1010101010, 0, 1'b0);
    push(1'b1, 10'b1000011110, 41, 1'b0);
    do_reset(1'b1, 1'b1);
    wait_q(1, "tie_ack0");
    REQ0 = 1'b0;
    wait_q(0, "tie_ack1");
    REQ1 = 1'b0;
    wait_idle("tie_frames");

    // Continuous requests alternate 0,1,0,1.
    do_reset(1'b0, 1'b0);
    @(negedge SYSCLK);
    DATA0 = 8'h3C;
    DATA1 = 8'hC3;
    push(1'b0, 10'b1001111000, 0, 1'b0);
    push(1'b1, 10'b1110000110, 41, 1'b0);
    push(1'b0, 10'b1001111000, 41, 1'b0);
    push(1'b1, 10'b1110000110, 41, 1'b0);
    REQ0 = 1'b1;
    REQ1 = 1'b1;
    wait_q(0, "rr_acks");
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    wait_idle("rr_frames");

    // REQ1 pulsed during a client 0 frame is ignored.
    push(1'b0, 10'b1100000010, 0, 1'b0);
    DATA0 = 8'h81;
    REQ0 = 1'b1;
    wait_q(0, "busy_ack0");
    REQ0 = 1'b0;
    repeat (10) @(negedge SYSCLK);
    DATA1 = 8'hEE;
    REQ1 = 1'b1;
    repeat (8) @(negedge SYSCLK);
    REQ1 = 1'b0;
    wait_idle("busy_frame");
    repeat (5) @(negedge SYSCLK);
    chk("busy_txd_after", 64'(TXD), 64'd1);
    chk("busy_busy_after", 64'(BUSY), 64'd0);

    // Reset during data bit 3 aborts; held REQ0 restarts a full frame.
    push(1'b0, 10'b1010110100, 0, 1'b1);
    DATA0 = 8'h5A;
    REQ0 = 1'b1;
    wait_q(0, "abort_ack0");
    repeat (16) @(negedge SYSCLK);
    #2 NSYSRESET = 1'b0;
    #1;
    chk("abort_txd_async", 64'(TXD), 64'd1);
    chk("abort_busy_async", 64'(BUSY), 64'd0);
    chk("abort_ack_async", 64'({ACK1, ACK0}), 64'd0);
    push(1'b0, 10'b1010110100, 0, 1'b0);
    repeat (3) @(negedge SYSCLK);
    NSYSRESET = 1'b1;
    wait_q(0, "restart_ack0");
    REQ0 = 1'b0;
    wait_idle("restart_frame");
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Default 87 clocks per bit, all-zero byte.
    @(negedge SYSCLK);
    data0_87 = 8'h00;
    req0_87 = 1'b1;
    t = 0;
    while (!ack0_87 && t < 20) begin
      @(negedge SYSCLK);
      t++;
    end
    req0_87 = 1'b0;
    if (!ack0_87) fail_now("b87_ack");
    chk("b87_last_gnt", 64'(gnt_87), 64'd0);
    low_cnt = 0;
    high_cnt = 0;
    busy_cnt = 0;
    while (busy_87 && busy_cnt < 1000) begin
      if (txd_87) high_cnt++;
      else low_cnt++;
      busy_cnt++;
      @(negedge SYSCLK);
    end
    chk("b87_low", 64'(low_cnt), 64'd783);
    chk("b87_stop", 64'(high_cnt), 64'd87);
    chk("b87_busy", 64'(busy_cnt), 64'd870);
    chk("b87_idle_txd", 64'(txd_87), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, SYSCLK cycles per UART bit (10 MHz / 115200 baud); supported range 2..65535.
REQ-002 SYSCLK  input  1  system clock; all state advances on the rising edge.
REQ-003 NSYSRESET  input  1  reset; asynchronous, active-low.
REQ-004 REQ0  input  1  client 0 transmit request.
REQ-005 DATA0  input  8  client 0 byte; held stable while REQ0 is high.
REQ-006 ACK0  output  1  one-cycle pulse; client 0 byte accepted.
REQ-007 REQ1  input  1  client 1 transmit request.
REQ-008 DATA1  input  8  client 1 byte; held stable while REQ1 is high.
REQ-009 ACK1  output  1  one-cycle pulse; client 1 byte accepted.
REQ-010 TXD  output  1  serial line, 8N1, idle high.
REQ-011 BUSY  output  1  frame in progress.
REQ-012 LAST_GNT  output  1  ID of the most recently granted client.

Function
REQ-013 The FSM SHALL have four states: IDLE, START, DATA, STOP. The only transitions are IDLE->START->DATA->STOP->IDLE.
REQ-014 In IDLE, at a rising edge where any REQ is sampled high, the block SHALL grant exactly one client and latch that client's DATA into the shift register. On the same edge it enters START and clears the 16-bit baud counter.
REQ-015 When both REQs are high in IDLE, the block SHALL grant the client not equal to LAST_GNT (round-robin). When only one REQ is high, it SHALL grant that client.
REQ-016 On the grant edge, the block SHALL update LAST_GNT to the granted ID. The granted ACK SHALL be registered high for exactly the following cycle.
REQ-017 DATA SHALL be sampled only on the grant edge. A REQ that drops before its grant edge SHALL produce no ACK and no frame.
REQ-018 REQs sampled while the FSM is outside IDLE SHALL be ignored (no ACK). A REQ still high in IDLE is a new request.
REQ-019 START, each of the 8 DATA bits, and STOP SHALL each last CLKS_PER_BIT cycles. The baud counter wraps to 0 at CLKS_PER_BIT-1 and advances the bit.
REQ-020 TXD SHALL be registered and glitch-free: 0 in START, data LSB-first in DATA, and 1 in STOP and IDLE.
REQ-021 A frame SHALL last exactly 10*CLKS_PER_BIT cycles. Back-to-back grants SHALL be spaced exactly 10*CLKS_PER_BIT+1 cycles, with one IDLE cycle for arbitration.
REQ-022 BUSY SHALL be high exactly when the state is not IDLE.
REQ-023 ACK0 and ACK1 SHALL never be high in the same cycle.

Reset
REQ-024 While NSYSRESET is low, the following SHALL hold immediately and asynchronously: state IDLE, TXD=1, BUSY=0, ACK0=ACK1=0, LAST_GNT=1 (client 0 wins the first tie), baud counter 0, bit index 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no ACK. After release, the first sampling edge is an IDLE arbitration edge.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-026 Single REQ0, DATA0=0xA5 -> ACK0 one-cycle pulse; TXD bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; BUSY high 40 cycles; LAST_GNT=0.
REQ-027 REQ0 and REQ1 high at reset release, DATA0=0x55, DATA1=0x0F, each REQ dropped after its ACK -> ACK0 first, ACK1 41 cycles later; LAST_GNT 0 then 1; two correct frames.
REQ-028 REQ0 and REQ1 held high continuously -> grants alternate 0,1,0,1; successive ACKs exactly 41 cycles apart; no double ACK.
REQ-029 REQ1 pulsed during client 0 DATA state and dropped before STOP ends -> no ACK1; TXD stays 1 after the frame; BUSY returns to 0.
REQ-030 NSYSRESET low during data bit 3 -> TXD=1 and BUSY=0 without waiting for a clock edge; after release with REQ0 held, a fresh frame starts with a full 4-cycle start bit.
REQ-031 Default CLKS_PER_BIT=87, DATA0=0x00 -> TXD low for 783 cycles, then high for 87 cycles of stop; BUSY high 870 cycles.
